// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module : enc_pkg
// Brief  : Shared definitions for the one-hot-to-binary encoder family.
//          Holds the occupancy state encoding, the payload bit layout and
//          the highest-set-bit index function.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package enc_pkg;

  // Occupancy of the main/skid register pair
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Payload layout: {index, err, zero}, with the index starting at bit 2
  localparam int c_zero_pos = 0;
  localparam int c_err_pos  = 1;
  localparam int c_idx_lsb  = 2;

  // Widest word any encoder variant accepts, and its index width
  localparam int c_max_n = 16;
  localparam int c_max_w = 4;

  // Index of the highest set bit; zero when the word is empty. The loop
  // runs upward, so later (higher) set bits overwrite earlier ones.
  function automatic logic [c_max_w-1:0] onehot_hi_index(input logic [c_max_n-1:0] word);
    logic [c_max_w-1:0] idx;
    idx = '0;
    for (int i = 0; i < c_max_n; i++) begin
      if (word[i]) idx = i[c_max_w-1:0];
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_core.sv
`default_nettype none
// ============================================================================
// Module : enc_core
// Brief  : Purely combinational N-line one-hot to W-bit binary encoder.
//          Reports the highest set index, plus flags for an empty word and
//          for any word that is not exactly one-hot.
// Ports  : word [N-1:0] in  - word to encode
//          idx  [W-1:0] out - index of the highest set bit (0 if empty)
//          err          out - word is empty or has more than one bit set
//          zero         out - word is all zeros
// Rev    : 1.0  initial release
// ============================================================================
module enc_core
  import enc_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] word,
  output logic [W-1:0] idx,
  output logic         err,
  output logic         zero
);

  localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

  logic [c_max_n-1:0] w_word_wide;
  logic [c_max_w-1:0] w_idx_wide;
  logic               w_multi;
  logic               w_unused;

  always_comb begin
    w_word_wide        = '0;
    w_word_wide[N-1:0] = word;
  end

  assign w_idx_wide = onehot_hi_index(w_word_wide);

  // Clearing the lowest set bit leaves something only if two or more were set
  assign w_multi = (word & (word - c_one)) != '0;

  assign zero = (word == '0);
  assign err  = zero | w_multi;
  assign idx  = w_idx_wide[W-1:0];

  // Upper index bits are always zero for N-line words
  assign w_unused = ^w_idx_wide;

endmodule
`default_nettype wire

// File: rtl/enc4to2_pipe.sv
`default_nettype none
// ============================================================================
// Module : enc4to2_pipe
// Brief  : Registered one-hot-to-binary encoder with valid/ready handshakes
//          on both sides and a 2-entry skid buffer, so in_ready is a plain
//          register with no combinational path from out_ready.
// Ports  : clk                  in  - clock, rising edge
//          rst                  in  - synchronous reset, active high
//          in_valid             in  - I holds a word to encode
//          in_ready             out - word can be accepted (registered)
//          I         [N-1:0]    in  - one-hot input word
//          out_valid            out - O/out_err/out_zero are valid
//          out_ready            in  - consumer takes the output
//          O         [W-1:0]    out - index of highest set bit
//          out_err              out - accepted word was not exactly one-hot
//          out_zero             out - accepted word was all zeros
//          err_count [CW-1:0]   out - saturating count of erroneous words
// Rev    : 1.0  initial release
// ============================================================================
module enc4to2_pipe
  import enc_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = $clog2(N),
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  I,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  O,
  output logic          out_err,
  output logic          out_zero,
  output logic [CW-1:0] err_count
);

  localparam int PW = W + 2;

  state_t          r_state;
  logic [PW-1:0]   r_m;
  logic [PW-1:0]   r_s;
  logic            r_in_ready;
  logic [CW-1:0]   r_err_count;

  logic [N-1:0]    w_word;
  logic [W-1:0]    w_idx;
  logic            w_err;
  logic            w_zero;
  logic [PW-1:0]   w_pay;
  logic            w_accept;
  logic            w_xfer;

  // Mask the word while invalid so an undriven I cannot reach the encoder
  assign w_word = in_valid ? I : '0;

  enc_core #(
    .N (N),
    .W (W)
  ) u_core (
    .word (w_word),
    .idx  (w_idx),
    .err  (w_err),
    .zero (w_zero)
  );

  always_comb begin
    w_pay                     = '0;
    w_pay[c_idx_lsb +: W]     = w_idx;
    w_pay[c_err_pos]          = w_err;
    w_pay[c_zero_pos]         = w_zero;
  end

  assign w_accept = in_valid && r_in_ready;
  assign w_xfer   = (r_state != EMPTY) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_m        <= '0;
      r_s        <= '0;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_m     <= w_pay;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_accept && w_xfer) begin
            r_m <= w_pay;
          end else if (w_accept) begin
            // Consumer stalled: park the new word behind M and close input
            r_s        <= w_pay;
            r_state    <= TWO;
            r_in_ready <= 1'b0;
          end else if (w_xfer) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          if (w_xfer) begin
            r_m        <= r_s;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_accept && w_pay[c_err_pos] && (r_err_count != {CW{1'b1}})) begin
      r_err_count <= r_err_count + CW'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign O         = r_m[c_idx_lsb +: W];
  assign out_err   = r_m[c_err_pos];
  assign out_zero  = r_m[c_zero_pos];
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_enc4to2_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_enc4to2_pipe
// Brief  : Self-checking bench for enc4to2_pipe. A queue-based reference
//          model tracks every word in flight and is compared against the
//          outputs each cycle; directed phases add literal expectations.
// Rev    : 1.0  initial release
// ============================================================================
module tb_enc4to2_pipe;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  I;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  O;
  logic          out_err;
  logic          out_zero;
  logic [CW-1:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: words in flight (front = visible on outputs)
  int q[$];
  int m_cnt = 0;
  bit live  = 1'b0;

  enc4to2_pipe #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .I         (I),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .O         (O),
    .out_err   (out_err),
    .out_zero  (out_zero),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result as the integer idx*4 + err*2 + zero
  function automatic int expect_of(input logic [N-1:0] v);
    int idx, ones;
    idx  = 0;
    ones = $countones(v);
    for (int i = 0; i < N; i++) if (v[i]) idx = i;
    return idx * 4 + ((ones != 1) ? 2 : 0) + ((v == 0) ? 1 : 0);
  endfunction

  // Compare on the falling edge, then advance the model across the next
  // rising edge using the inputs that are stable through it.
  always @(negedge clk) begin
    bit acc, xfer;
    int e;
    if (live) begin
      chk("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
      chk("in_ready", int'(in_ready), (q.size() < 2) ? 1 : 0);
      chk("err_count", int'(err_count), m_cnt);
      if (q.size() != 0)
        chk("payload", int'(O) * 4 + int'(out_err) * 2 + int'(out_zero), q[0]);
    end
    if (rst) begin
      q.delete();
      m_cnt = 0;
      live  = 1'b1;
    end else if (live) begin
      xfer = (q.size() != 0) && out_ready;
      acc  = in_valid && (q.size() < 2);
      if (xfer) void'(q.pop_front());
      if (acc) begin
        e = expect_of(I);
        q.push_back(e);
        if ((e & 2) != 0 && m_cnt < 255) m_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; I = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] sweep [4];
    int n_acc, cyc;
    bit a;
    sweep[0] = 4'b0001; sweep[1] = 4'b0010; sweep[2] = 4'b0100; sweep[3] = 4'b1000;

    do_reset();
    tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_O", int'(O), 0);
    chk("rst_flags", int'(out_err) * 2 + int'(out_zero), 0);
    chk("rst_err_count", int'(err_count), 0);

    // One-hot sweep, full throughput
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      I = sweep[k];
      tick();
      chk("sweep_valid", int'(out_valid), 1);
      chk("sweep_O", int'(O), k);
      chk("sweep_err", int'(out_err), 0);
    end

    // Error words
    I = 4'b0000;
    tick();
    chk("zero_O", int'(O), 0);
    chk("zero_flag", int'(out_zero), 1);
    chk("zero_err", int'(out_err), 1);
    chk("zero_cnt", int'(err_count), 1);
    I = 4'b1010;
    tick();
    chk("multi_O", int'(O), 3);
    chk("multi_err", int'(out_err), 1);
    chk("multi_zero", int'(out_zero), 0);
    chk("multi_cnt", int'(err_count), 2);
    in_valid = 1'b0;
    tick();

    // Backpressure: only two words fit
    out_ready = 1'b0;
    in_valid  = 1'b1;
    I = 4'b0001; tick();
    chk("bp_ready1", int'(in_ready), 1);
    I = 4'b0010; tick();
    chk("bp_ready2", int'(in_ready), 0);
    I = 4'b0100; tick();
    chk("bp_ready3", int'(in_ready), 0);
    chk("bp_hold_O", int'(O), 0);
    I = 4'b1000; tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_second_O", int'(O), 1);
    chk("bp_reopen", int'(in_ready), 1);
    tick();
    chk("bp_drained", int'(out_valid), 0);

    // Reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    I = 4'b0000; tick();
    I = 4'b0011; tick();
    chk("full_before_rst", int'(in_ready), 0);
    do_reset();
    chk("rst2_out_valid", int'(out_valid), 0);
    chk("rst2_in_ready", int'(in_ready), 1);
    chk("rst2_err_count", int'(err_count), 0);
    in_valid = 1'b1; out_ready = 1'b1; I = 4'b0100;
    tick();
    chk("post_rst_O", int'(O), 2);
    chk("post_rst_valid", int'(out_valid), 1);
    in_valid = 1'b0;
    tick();

    // Saturation of the error counter
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; I = '0;
    repeat (300) tick();
    chk("sat_cnt", int'(err_count), 255);
    in_valid = 1'b0;
    tick();

    // Randomized handshakes against the model
    do_reset();
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if (!in_valid)                  I = N'($urandom);
      else if ($urandom_range(0, 1))  I = N'(1) << $urandom_range(0, N - 1);
      else                            I = N'($urandom);
      a = in_valid && in_ready;
      tick();
      if (a) n_acc++;
      cyc++;
    end
    chk("rand_accepted", n_acc, 1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("rand_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/enc4to2_pipe.md
Name: enc4to2_pipe

Overview:
Registered one-hot-to-binary encoder, the inverse of the team's 2-to-4 decoder.
- Accepts N-bit one-hot words on a valid/ready input.
- Emits the W-bit binary index plus error flags on a valid/ready output.
- A 2-entry skid buffer holds results, so in_ready is a pure register with no combinational path from out_ready.
- Sits between a one-hot select source (e.g. decoder output, request lines) and binary-indexed consumers.

Parameters:
N, 4, input word width (number of one-hot lines); legal values 2..16.
W, $clog2(N), output index width; derived, not overridden.
CW, 8, width of the saturating error counter.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  I holds a word to encode.
in_ready  output  1  block can accept a word this cycle (registered).
I  input  N  one-hot input word.
out_valid  output  1  O/out_err/out_zero are valid.
out_ready  input  1  consumer takes the output this cycle.
O  output  W  binary index of the highest set bit of the accepted word.
out_err  output  1  accepted word was not exactly one-hot.
out_zero  output  1  accepted word was all zeros.
err_count  output  CW  saturating count of accepted words with out_err=1.

Behaviour:
- Transfers: input accept = in_valid && in_ready; output transfer = out_valid && out_ready; both sampled at the rising edge of clk.
- Encoding rule, computed combinationally on I, registered on accept:
  - O = index of the highest set bit, so 4'b1000 -> 2'b11 and 4'b0001 -> 2'b00 (exact inverse of the decoder).
  - out_zero = (I == 0); in that case O = 0.
  - out_err = out_zero || more than one bit set; multi-hot words still report the highest index.
- Storage: main register M (drives the outputs) and skid register S; each holds {O, out_err, out_zero}.
- State machine on occupancy:
  - EMPTY:
    - accept -> load M -> ONE.
  - ONE:
    - accept && transfer -> load M -> ONE.
    - accept && !transfer -> load S -> TWO.
    - !accept && transfer -> EMPTY.
    - neither -> hold.
  - TWO:
    - transfer -> M <= S -> ONE.
    - no transfer -> hold.
    - No accept can occur in TWO (in_ready=0).
- in_ready is registered: 1 when the next state is EMPTY or ONE, 0 when it is TWO.
- out_valid = (state != EMPTY), driven from the state register.
- Latency: a word accepted at edge k is visible on O at edge k+1 if M was empty or drained at edge k.
- Throughput: one word per cycle sustained while out_ready=1.
- Backpressure:
  - out_ready low for 2+ cycles fills S, then in_ready drops.
  - No data is lost or reordered; outputs stay stable while out_valid && !out_ready.
- err_count: +1 on each accepted word whose out_err=1; saturates at 2^CW-1 and never wraps.
- Reset (synchronous, any cycle including mid-transfer):
  - state=EMPTY, out_valid=0, in_ready=1.
  - O=0, out_err=0, out_zero=0, err_count=0.
  - Contents of S are discarded.
- While in_valid=0, I is ignored, and X on I must not propagate.

Decomposition:
- Shared package enc_pkg:
  - State encoding EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - Payload field layout constants (O, err, zero bit positions).
  - Function onehot_hi_index(N-bit) -> W-bit, reused by future encoder variants.
- One sub-module is natural: enc_core, purely combinational N->{W, err, zero} encoder.
- The top level holds the state machine, skid buffer and counter.

Test Plan:
- Sweep I=0001,0010,0100,1000 with out_ready=1 -> O=00,01,10,11 one cycle later; out_err=0; no bubbles.
- I=0000 -> O=00, out_zero=1, out_err=1, err_count=1; then I=1010 -> O=11, out_err=1, out_zero=0, err_count=2.
- Stream 4 words with out_ready held 0 -> first two accepted, in_ready=0 from the cycle after the second; release out_ready -> words emerge in order with no loss.
- Assert rst while in state TWO -> next cycle out_valid=0, in_ready=1, err_count=0; the next word encodes normally.
- Feed 300 zero words with CW=8 -> err_count stops at 255.
- Random valid/ready toggling over 1000 words against a reference model -> identical ordered output stream; outputs stable while stalled.
